// File: rtl/rv32i_defs.sv
// -----------------------------------------------------------------------------
// rv32i_defs
// Shared RV32I load/store definitions: funct3 access-format constants, the
// lsu_ctrl state encoding and small decode helpers used by the LSU.
// -----------------------------------------------------------------------------
package rv32i_defs;

    // Load formats (ir[14:12])
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store formats (ir[14:12])
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE0 = 3'd1,
        ST_WAIT0  = 3'd2,
        ST_ISSUE1 = 3'd3,
        ST_WAIT1  = 3'd4,
        ST_RESP   = 3'd5
    } lsu_state_t;

    // Byte-enable pattern for an access size (funct3[1:0]), before lane shift.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // An access is misaligned when it spills past the end of its word.
    // Bytes never spill; a halfword only spills from offset 3.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] offset);
        case (funct3[1:0])
            2'b01:   return (offset == 2'd3);
            2'b10:   return (offset != 2'd0);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ld_converter.sv
// -----------------------------------------------------------------------------
// ld_converter
// Extracts a byte/halfword/word from a 32-bit value and sign- or zero-extends
// it according to the load format.
// Ports:
//   data   - 32-bit source value
//   funct3 - load format (LB/LH/LW/LBU/LHU)
//   offset - byte offset of the field inside data
//   result - extended load value (0 for unsupported formats)
// -----------------------------------------------------------------------------
module ld_converter
    import rv32i_defs::*;
(
    input  logic [31:0] data,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] result
);

    logic [31:0] shifted;

    // NOTE: every always_comb output gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        result  = '0;
        shifted = data >> {offset, 3'b000};
        case (funct3)
            F3_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   result = shifted;
            F3_LBU:  result = {24'b0, shifted[7:0]};
            F3_LHU:  result = {16'b0, shifted[15:0]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl
// Load/store unit controller. Accepts one pipeline request at a time, issues
// one or two word-aligned memory accesses (misaligned accesses are split when
// SPLIT_EN=1, rejected otherwise), merges/extends load data and reports a
// one-cycle completion pulse.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   req_valid/req_ready      - request handshake (ready only when idle)
//   req_we, req_addr,
//   req_funct3, req_wdata    - request: store flag, byte address, format, data
//   resp_valid, resp_rdata,
//   resp_err                 - completion pulse, load result, illegal flag
//   mem_valid/mem_ready      - memory command handshake
//   mem_we, mem_addr,
//   mem_be, mem_wdata        - memory command (word aligned)
//   mem_rvalid, mem_rdata    - memory read return
// -----------------------------------------------------------------------------
module lsu_ctrl
    import rv32i_defs::*;
#(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,

    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,

    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,

    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_t state, state_d;

    // Captured request
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic        we_q;
    logic        split_q;
    // Second-access lanes, prepared at acceptance
    logic [3:0]  be_hi_q;
    logic [31:0] wdata_hi_q;
    // First read word of a split load
    logic [31:0] w0_q;

    // Request decode
    logic        accept;
    logic        req_mis;
    logic        req_illegal;
    logic [63:0] lane_data;
    logic [7:0]  lane_be;

    // Load merge
    logic [63:0] merged;
    logic [31:0] conv_in;
    logic [31:0] conv_out;

    assign accept  = req_valid && req_ready;
    assign req_mis = is_misaligned(req_funct3, req_addr[1:0]);

    always_comb begin
        if (req_we)
            req_illegal = (req_funct3 > F3_SW);
        else
            req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                          (req_funct3 == 3'b111);
        if (req_mis && !SPLIT_EN)
            req_illegal = 1'b1;
    end

    // Store data and byte mask placed across a 64-bit window spanning the
    // addressed word and the next one.
    assign lane_data = {32'b0, req_wdata} << {req_addr[1:0], 3'b000};
    assign lane_be   = {4'b0, size_mask(req_funct3[1:0])} << req_addr[1:0];

    // The second word only contributes while finishing a split load; the
    // shift by the original offset already realigns the field, so the
    // converter always sees it at offset 0.
    assign merged  = (state == ST_WAIT1) ? {mem_rdata, w0_q} : {32'b0, mem_rdata};
    assign conv_in = 32'(merged >> {addr_q[1:0], 3'b000});

    ld_converter u_ld_converter (
        .data   (conv_in),
        .funct3 (funct3_q),
        .offset (2'b00),
        .result (conv_out)
    );

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_d;
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:   if (accept)     state_d = req_illegal ? ST_RESP : ST_ISSUE0;
            ST_ISSUE0: if (mem_ready)  state_d = !we_q ? ST_WAIT0 :
                                                 (split_q ? ST_ISSUE1 : ST_RESP);
            ST_WAIT0:  if (mem_rvalid) state_d = split_q ? ST_ISSUE1 : ST_RESP;
            ST_ISSUE1: if (mem_ready)  state_d = we_q ? ST_RESP : ST_WAIT1;
            ST_WAIT1:  if (mem_rvalid) state_d = ST_RESP;
            ST_RESP:                   state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath and registered outputs, all driven from the next state so each
    // output is valid in the same cycle as the state it belongs to.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            addr_q     <= '0;
            funct3_q   <= '0;
            we_q       <= 1'b0;
            split_q    <= 1'b0;
            be_hi_q    <= '0;
            wdata_hi_q <= '0;
            w0_q       <= '0;
        end else begin
            req_ready  <= (state_d == ST_IDLE);
            mem_valid  <= (state_d == ST_ISSUE0) || (state_d == ST_ISSUE1);
            resp_valid <= (state_d == ST_RESP);
            // Response payload is cleared every cycle and only loaded on the
            // transition into RESP, so stores and errors report zero data.
            resp_rdata <= '0;
            resp_err   <= 1'b0;

            if (accept) begin
                addr_q     <= req_addr;
                funct3_q   <= req_funct3;
                we_q       <= req_we;
                split_q    <= req_mis;
                resp_err   <= req_illegal;
                be_hi_q    <= req_we ? lane_be[7:4] : 4'hF;
                wdata_hi_q <= lane_data[63:32];
                if (!req_illegal) begin
                    mem_we    <= req_we;
                    mem_addr  <= {req_addr[31:2], 2'b00};
                    mem_be    <= req_we ? lane_be[3:0] : 4'hF;
                    mem_wdata <= lane_data[31:0];
                end
            end

            if (state_d == ST_ISSUE1 && state != ST_ISSUE1) begin
                mem_addr  <= {addr_q[31:2], 2'b00} + 32'd4;
                mem_be    <= be_hi_q;
                mem_wdata <= wdata_hi_q;
            end

            if (state == ST_WAIT0 && mem_rvalid)
                w0_q <= mem_rdata;

            if ((state == ST_WAIT0 || state == ST_WAIT1) && state_d == ST_RESP)
                resp_rdata <= conv_out;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl
// Directed bench for lsu_ctrl: a table of request vectors with hand-computed
// memory accesses and responses, plus sequences for reset, back-pressure and
// reset during an outstanding load. Two instances cover SPLIT_EN=1 and 0.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;

    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_wdata = '0;
    logic        mem_ready = 1'b1;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        rv0, rv1;
    logic        rdy0, rdy1, rsv0, rsv1, err0, err1, mv0, mv1, mwe0, mwe1;
    logic [31:0] rd0, rd1, ma0, ma1, mwd0, mwd1;
    logic [3:0]  mbe0, mbe1;

    logic        s_rdy, s_rsv, s_err, s_mv, s_mwe;
    logic [31:0] s_rd, s_ma, s_mwd;
    logic [3:0]  s_mbe;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign rv0 = req_valid && !sel;
    assign rv1 = req_valid &&  sel;

    assign s_rdy = sel ? rdy1 : rdy0;
    assign s_rsv = sel ? rsv1 : rsv0;
    assign s_err = sel ? err1 : err0;
    assign s_rd  = sel ? rd1  : rd0;
    assign s_mv  = sel ? mv1  : mv0;
    assign s_mwe = sel ? mwe1 : mwe0;
    assign s_ma  = sel ? ma1  : ma0;
    assign s_mbe = sel ? mbe1 : mbe0;
    assign s_mwd = sel ? mwd1 : mwd0;

    lsu_ctrl #(.SPLIT_EN(1'b1)) dut_split (
        .clk(clk), .rst(rst),
        .req_valid(rv0), .req_ready(rdy0), .req_we(req_we), .req_addr(req_addr),
        .req_funct3(req_funct3), .req_wdata(req_wdata),
        .resp_valid(rsv0), .resp_rdata(rd0), .resp_err(err0),
        .mem_valid(mv0), .mem_ready(mem_ready), .mem_we(mwe0), .mem_addr(ma0),
        .mem_be(mbe0), .mem_wdata(mwd0),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    lsu_ctrl #(.SPLIT_EN(1'b0)) dut_nosplit (
        .clk(clk), .rst(rst),
        .req_valid(rv1), .req_ready(rdy1), .req_we(req_we), .req_addr(req_addr),
        .req_funct3(req_funct3), .req_wdata(req_wdata),
        .resp_valid(rsv1), .resp_rdata(rd1), .resp_err(err1),
        .mem_valid(mv1), .mem_ready(mem_ready), .mem_we(mwe1), .mem_addr(ma1),
        .mem_be(mbe1), .mem_wdata(mwd1),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        string       name;
        logic        sel;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] w0;
        logic [31:0] w1;
        int          n_acc;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] d0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] d1;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic s, input logic we,
                                input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] w0,
                                input logic [31:0] w1, input int n_acc,
                                input logic [31:0] a0, input logic [3:0] be0,
                                input logic [31:0] d0, input logic [31:0] a1,
                                input logic [3:0] be1, input logic [31:0] d1,
                                input logic [31:0] rdata, input logic err, input int lat);
        vec_t v;
        v.name = name; v.sel = s; v.we = we; v.f3 = f3; v.addr = addr;
        v.wdata = wdata; v.w0 = w0; v.w1 = w1; v.n_acc = n_acc;
        v.a0 = a0; v.be0 = be0; v.d0 = d0; v.a1 = a1; v.be1 = be1; v.d1 = d1;
        v.rdata = rdata; v.err = err; v.lat = lat;
        return v;
    endfunction

    // Issues one request, acts as a zero-wait memory (read data one cycle
    // after acceptance) and compares accesses, latency and response.
    task automatic run_vec(input vec_t v);
        logic [31:0] acc_addr [4];
        logic [3:0]  acc_be   [4];
        logic [31:0] acc_wd   [4];
        logic        acc_we   [4];
        int          n    = 0;
        logic        pend = 1'b0;
        logic        got  = 1'b0;
        int          lat  = -1;
        logic [31:0] got_rd  = '0;
        logic        got_err = 1'b0;

        for (int i = 0; i < 4; i++) begin
            acc_addr[i] = '0; acc_be[i] = '0; acc_wd[i] = '0; acc_we[i] = 1'b0;
        end

        @(negedge clk);
        sel = v.sel;
        #1;
        check({v.name, " req_ready idle"}, 32'(s_rdy), 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_addr   = v.addr;
        req_funct3 = v.f3;
        req_wdata  = v.wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;

        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            if (pend) begin
                mem_rvalid = 1'b1;
                mem_rdata  = (n == 1) ? v.w0 : v.w1;
                pend       = 1'b0;
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = '0;
            end
            if (c == 1)
                check({v.name, " req_ready busy"}, 32'(s_rdy), 32'd0);
            if (s_mv && n < 4) begin
                acc_addr[n] = s_ma; acc_be[n] = s_mbe; acc_wd[n] = s_mwd; acc_we[n] = s_mwe;
                n++;
                if (!s_mwe) pend = 1'b1;
            end
            if (s_rsv) begin
                got = 1'b1; lat = c; got_rd = s_rd; got_err = s_err;
            end
        end
        mem_rvalid = 1'b0;

        check({v.name, " latency"}, 32'(lat), 32'(v.lat));
        check({v.name, " accesses"}, 32'(n), 32'(v.n_acc));
        check({v.name, " resp_rdata"}, got_rd, v.rdata);
        check({v.name, " resp_err"}, 32'(got_err), 32'(v.err));
        if (v.n_acc >= 1) begin
            check({v.name, " addr0"}, acc_addr[0], v.a0);
            check({v.name, " be0"}, 32'(acc_be[0]), 32'(v.be0));
            check({v.name, " we0"}, 32'(acc_we[0]), 32'(v.we));
            if (v.we) check({v.name, " wdata0"}, acc_wd[0], v.d0);
        end
        if (v.n_acc >= 2) begin
            check({v.name, " addr1"}, acc_addr[1], v.a1);
            check({v.name, " be1"}, 32'(acc_be[1]), 32'(v.be1));
            check({v.name, " we1"}, 32'(acc_we[1]), 32'(v.we));
            if (v.we) check({v.name, " wdata1"}, acc_wd[1], v.d1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //                name             sel we  f3      addr          wdata         w0            w1          n  a0            be0   d0            a1            be1   d1            rdata         err lat
        vecs[0]  = mk("lw_aligned",     0, 0, 3'b010, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 32'h0,        1, 32'h0000_0100, 4'hF, 32'h0,         32'h0,         4'h0, 32'h0,         32'hDEAD_BEEF, 0, 3);
        vecs[1]  = mk("lh_split",       0, 0, 3'b001, 32'h0000_0203, 32'h0,         32'h1122_3344, 32'h5566_7788, 2, 32'h0000_0200, 4'hF, 32'h0,       32'h0000_0204, 4'hF, 32'h0,         32'hFFFF_8811, 0, 5);
        vecs[2]  = mk("sw_split",       0, 1, 3'b010, 32'h0000_0102, 32'hAABB_CCDD, 32'h0,         32'h0,        2, 32'h0000_0100, 4'hC, 32'hCCDD_0000, 32'h0000_0104, 4'h3, 32'h0000_AABB, 32'h0,         0, 3);
        vecs[3]  = mk("sb_off3",        0, 1, 3'b000, 32'h0000_0103, 32'h1234_565A, 32'h0,         32'h0,        1, 32'h0000_0100, 4'h8, 32'h5A00_0000, 32'h0,         4'h0, 32'h0,         32'h0,         0, 2);
        vecs[4]  = mk("sh_off1",        0, 1, 3'b001, 32'h0000_0201, 32'h0000_BEEF, 32'h0,         32'h0,        1, 32'h0000_0200, 4'h6, 32'h00BE_EF00, 32'h0,         4'h0, 32'h0,         32'h0,         0, 2);
        vecs[5]  = mk("lb_off2",        0, 0, 3'b000, 32'h0000_0002, 32'h0,         32'h0080_0000, 32'h0,        1, 32'h0000_0000, 4'hF, 32'h0,         32'h0,         4'h0, 32'h0,         32'hFFFF_FF80, 0, 3);
        vecs[6]  = mk("lhu_off1",       0, 0, 3'b101, 32'h0000_0001, 32'h0,         32'hAB98_76CD, 32'h0,        1, 32'h0000_0000, 4'hF, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0000_9876, 0, 3);
        vecs[7]  = mk("lw_wrap",        0, 0, 3'b010, 32'hFFFF_FFFE, 32'h0,         32'h4433_2211, 32'h8877_6655, 2, 32'hFFFF_FFFC, 4'hF, 32'h0,       32'h0000_0000, 4'hF, 32'h0,         32'h6655_4433, 0, 5);
        vecs[8]  = mk("sw_wrap",        0, 1, 3'b010, 32'hFFFF_FFFF, 32'h0102_0304, 32'h0,         32'h0,        2, 32'hFFFF_FFFC, 4'h8, 32'h0400_0000, 32'h0000_0000, 4'h7, 32'h0001_0203, 32'h0,         0, 3);
        vecs[9]  = mk("sh_split",       0, 1, 3'b001, 32'h0000_0103, 32'h0000_CAFE, 32'h0,         32'h0,        2, 32'h0000_0100, 4'h8, 32'hFE00_0000, 32'h0000_0104, 4'h1, 32'h0000_00CA, 32'h0,         0, 3);
        vecs[10] = mk("ld_f3_011",      0, 0, 3'b011, 32'h0000_0100, 32'h0,         32'h0,         32'h0,        0, 32'h0,         4'h0, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         1, 1);
        vecs[11] = mk("st_f3_011",      0, 1, 3'b011, 32'h0000_0100, 32'h1234_5678, 32'h0,         32'h0,        0, 32'h0,         4'h0, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         1, 1);
        vecs[12] = mk("ld_f3_110",      0, 0, 3'b110, 32'h0000_0100, 32'h0,         32'h0,         32'h0,        0, 32'h0,         4'h0, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         1, 1);
        vecs[13] = mk("lw_mis_nosplit", 1, 0, 3'b010, 32'h0000_0001, 32'h0,         32'h0,         32'h0,        0, 32'h0,         4'h0, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         1, 1);
        vecs[14] = mk("lh_off3_nosplit",1, 0, 3'b001, 32'h0000_0003, 32'h0,         32'h0,         32'h0,        0, 32'h0,         4'h0, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         1, 1);
        vecs[15] = mk("lw_al_nosplit",  1, 0, 3'b010, 32'h0000_0008, 32'h0,         32'h1357_9BDF, 32'h0,        1, 32'h0000_0008, 4'hF, 32'h0,         32'h0,         4'h0, 32'h0,         32'h1357_9BDF, 0, 3);
        vecs[16] = mk("lh_off1_nosplit",1, 0, 3'b001, 32'h0000_0001, 32'h0,         32'h00F0_0000, 32'h0,        1, 32'h0000_0000, 4'hF, 32'h0,         32'h0,         4'h0, 32'h0,         32'hFFFF_F000, 0, 3);

        // Reset state
        @(negedge clk);
        check("rst req_ready", 32'(rdy0), 32'd0);
        check("rst mem_valid", 32'(mv0), 32'd0);
        check("rst resp_valid", 32'(rsv0), 32'd0);
        check("rst resp_err", 32'(err0), 32'd0);
        check("rst resp_rdata", rd0, 32'h0);
        check("rst mem_addr", ma0, 32'h0);
        check("rst nosplit req_ready", 32'(rdy1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post-rst req_ready", 32'(rdy0), 32'd1);

        // Table
        for (int i = 0; i < 17; i++)
            run_vec(vecs[i]);
        sel = 1'b0;

        // Back-pressure: LBU at 0x301, mem_ready low for 4 cycles, plus a
        // stray rvalid during ISSUE0 that must be ignored.
        begin
            logic got = 1'b0;
            int   lat = -1;
            logic [31:0] rd = '0;
            @(negedge clk);
            mem_ready  = 1'b0;
            req_valid  = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0301;
            req_funct3 = 3'b100; req_wdata = '0;
            @(posedge clk);
            #1 req_valid = 1'b0;
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                mem_rvalid = (c == 2);
                mem_rdata  = (c == 2) ? 32'hFFFF_FFFF : 32'h0;
                check($sformatf("stall mem_valid c%0d", c), 32'(mv0), 32'd1);
                check($sformatf("stall mem_addr c%0d", c), ma0, 32'h0000_0300);
                check($sformatf("stall mem_be c%0d", c), 32'(mbe0), 32'hF);
                if (c == 4) mem_ready = 1'b1;
            end
            @(negedge clk);
            check("stall wait0 mem_valid", 32'(mv0), 32'd0);
            mem_rvalid = 1'b1; mem_rdata = 32'h0000_F000;
            for (int c = 6; c <= 20 && !got; c++) begin
                @(negedge clk);
                mem_rvalid = 1'b0; mem_rdata = '0;
                if (rsv0) begin got = 1'b1; lat = c; rd = rd0; end
            end
            check("stall latency", 32'(lat), 32'd6);
            check("stall lbu rdata", rd, 32'h0000_00F0);
        end

        // Reset while WAIT0, then a late rvalid
        begin
            logic seen = 1'b0;
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0100;
            req_funct3 = 3'b010;
            @(posedge clk);
            #1 req_valid = 1'b0;
            @(negedge clk);             // ISSUE0
            @(negedge clk);             // WAIT0
            rst = 1'b1;
            #1;
            check("midrst mem_valid", 32'(mv0), 32'd0);
            check("midrst req_ready", 32'(rdy0), 32'd0);
            check("midrst resp_valid", 32'(rsv0), 32'd0);
            @(negedge clk);
            rst = 1'b0;
            mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
            @(negedge clk);
            mem_rvalid = 1'b0; mem_rdata = '0;
            check("midrst req_ready after", 32'(rdy0), 32'd1);
            if (rsv0) seen = 1'b1;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (rsv0) seen = 1'b1;
            end
            check("midrst no resp", 32'(seen), 32'd0);
        end

        // Recovery after the abandoned access
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
